// File: rtl/bram128_pkg.sv
// Shared constants and FSM encoding for the 64x128-bit block RAM read streamer.
package bram128_pkg;

   localparam int BRAM_DW    = 128;
   localparam int BRAM_WL    = 64;
   localparam int BRAM_AW    = 13;
   localparam int WORD_SHIFT = 2;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   typedef enum logic [0:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN
   } state_e;

endpackage

// File: rtl/bram128_rd_stream_fifo.sv
// Small synchronous FIFO with a registered occupancy count; head is visible
// combinationally so it can drive the output stream directly.
module stream_fifo #(
   parameter  int DW = 128,
   parameter  int FD = 4,
   localparam int CW = $clog2(FD + 1),
   localparam int PW = (FD > 1) ? $clog2(FD) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   logic [DW-1:0] mem [FD];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(FD));
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= bump(wr_ptr);
         if (pop_ok)  rd_ptr <= bump(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/bram128_rd_stream.sv
// Streams len consecutive RAM words starting at base out as a valid/ready
// stream, absorbing the RAM's one-cycle read latency in a small FIFO.
module bram128_rd_stream
   import bram128_pkg::*;
#(
   parameter  int DW = BRAM_DW,
   parameter  int WL = BRAM_WL,
   parameter  int AW = BRAM_AW,
   parameter  int FD = 4,
   localparam int IW = $clog2(WL),
   localparam int LW = IW + 1,
   localparam int CW = $clog2(FD + 1)
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          start,
   input  logic [IW-1:0] base,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic          bram_EN,
   output logic [3:0]    bram_WE,
   output logic [AW-1:0] bram_A,
   input  logic [DW-1:0] bram_Do,
   output logic          m_tvalid,
   input  logic          m_tready,
   output logic [DW-1:0] m_tdata,
   output logic          m_tlast,
   output state_e        dbg_state
);

   // Stream handshake: a beat moves on a cycle where m_tvalid & m_tready; while
   // m_tvalid is high and m_tready low, m_tdata and m_tlast stay unchanged.

   state_e        state;
   logic [IW-1:0] base_q;
   logic [LW-1:0] len_q;
   logic [LW-1:0] issued;
   logic [LW-1:0] beats;
   logic          iss_v;
   logic          cap_v;

   logic [DW-1:0] fifo_head;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic          fifo_full;
   logic          pop;
   logic [CW:0]   occ;
   logic          can_issue;
   logic [IW-1:0] next_idx;

   function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] idx);
      return {{(AW - IW - WORD_SHIFT){1'b0}}, idx, {WORD_SHIFT{1'b0}}};
   endfunction

   assign busy      = (state == RUN);
   assign bram_EN   = busy;
   assign bram_WE   = 4'b0000;
   assign dbg_state = state;

   assign m_tvalid  = ~fifo_empty;
   assign m_tdata   = fifo_empty ? '0 : fifo_head;
   assign m_tlast   = m_tvalid & (beats == len_q - 1'b1);
   assign pop       = m_tvalid & m_tready;

   // Words already buffered plus reads issued but not yet captured; all registered,
   // so m_tready never reaches the address path combinationally.
   assign occ       = {1'b0, fifo_count} + {{CW{1'b0}}, cap_v} + {{CW{1'b0}}, iss_v};
   assign can_issue = busy && (issued < len_q) && (occ < (CW + 1)'(FD)) && !fifo_full;
   assign next_idx  = base_q + issued[IW-1:0];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         base_q <= '0;
         len_q  <= '0;
         issued <= '0;
         beats  <= '0;
         iss_v  <= 1'b0;
         cap_v  <= 1'b0;
         done   <= 1'b0;
         bram_A <= '0;
      end else begin
         done  <= 1'b0;
         cap_v <= iss_v;
         iss_v <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     state  <= RUN;
                     base_q <= base;
                     len_q  <= len;
                     bram_A <= addr_of(base);
                     iss_v  <= 1'b1;
                     issued <= LW'(1);
                     beats  <= '0;
                  end
               end
            end
            RUN: begin
               if (can_issue) begin
                  bram_A <= addr_of(next_idx);
                  iss_v  <= 1'b1;
                  issued <= issued + 1'b1;
               end
               if (pop) beats <= beats + 1'b1;
               if (pop && m_tlast) begin
                  state  <= IDLE;
                  done   <= 1'b1;
                  issued <= '0;
                  beats  <= '0;
                  cap_v  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // bram_Do is only meaningful the cycle after an issue, so capture follows iss_v.
   stream_fifo #(
      .DW (DW),
      .FD (FD)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RST_N),
      .push      (cap_v),
      .push_data (bram_Do),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule

// File: tb/tb_bram128_rd_stream.sv
// Bench for bram128_rd_stream: RAM model, command driver, random backpressure,
// and a queue-based scoreboard checked by an independent monitor.
module tb_bram128_rd_stream;
   import bram128_pkg::*;

   localparam int DW = 128;
   localparam int WL = 64;
   localparam int AW = 13;
   localparam int FD = 4;
   localparam int IW = 6;
   localparam int LW = 7;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          start = 1'b0;
   logic [IW-1:0] base = '0;
   logic [LW-1:0] len = '0;
   logic          busy, done, bram_EN;
   logic [3:0]    bram_WE;
   logic [AW-1:0] bram_A;
   logic [DW-1:0] bram_Do;
   logic          m_tvalid, m_tlast;
   logic          m_tready = 1'b1;
   logic [DW-1:0] m_tdata;
   state_e        dbg_state;

   logic [DW-1:0] mem [WL];
   logic [IW-1:0] ram_addr_q = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ready_pct = 100;
   int cmd_base = 0;
   int beats_seen = 0;

   logic [DW-1:0] exp_q[$];
   logic          exp_last_q[$];

   bram128_rd_stream dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .start     (start),
      .base      (base),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .bram_EN   (bram_EN),
      .bram_WE   (bram_WE),
      .bram_A    (bram_A),
      .bram_Do   (bram_Do),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tdata   (m_tdata),
      .m_tlast   (m_tlast),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / cycle counter / RAM model ----------------
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(posedge CLK) if (bram_EN) ram_addr_q <= bram_A[IW+1:2];
   assign bram_Do = bram_EN ? mem[ram_addr_q] : '0;

   // Backpressure source: changes just after the active edge.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         m_tready = ($urandom_range(0, 99) < ready_pct);
      end
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_en"}, bram_EN, 0);
      check({tag, "_we"}, bram_WE, 0);
      check({tag, "_addr"}, bram_A, 0);
      check({tag, "_tvalid"}, m_tvalid, 0);
      check({tag, "_tdata"}, m_tdata, 0);
      check({tag, "_tlast"}, m_tlast, 0);
   endtask

   // ---------------- driver ----------------
   task automatic start_cmd(input int b, input int l, input bit now, output int t0);
      if (!now) @(negedge CLK);
      t0       = cyc;
      start    = 1'b1;
      base     = IW'(b);
      len      = LW'(l);
      cmd_base = b;
      for (int k = 0; k < l; k++) begin
         exp_q.push_back(mem[(b + k) % WL]);
         exp_last_q.push_back(k == l - 1);
      end
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_done(input int t0, input int l, input bit timing);
      int first_v = -1;
      int done_at = -1;
      for (int n = 0; n < 3000 && done_at < 0; n++) begin
         if (n > 0) @(negedge CLK);
         if (n == 0) check("busy_after_start", busy, (l != 0));
         if (m_tvalid && first_v < 0) first_v = cyc - t0;
         if (done) done_at = cyc - t0;
      end
      if (done_at < 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: got no done expected done within 3000 cycles");
      end else begin
         check("busy_at_done", busy, 0);
         check("queue_drained", exp_q.size(), 0);
         if (timing) begin
            check("done_cycle", done_at, (l == 0) ? 1 : l + 3);
            check("first_valid_cycle", first_v, (l == 0) ? -1 : 3);
         end
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   logic          prev_busy = 1'b0;
   logic [AW-1:0] prev_a = '0;
   int            iss_cnt = 0;
   int            beat_cnt = 0;

   always @(negedge CLK) begin
      if (!RST_N) begin
         prev_stall = 1'b0;
         prev_busy  = 1'b0;
         iss_cnt    = 0;
         beat_cnt   = 0;
      end else begin
         check("we_zero", bram_WE, 0);
         check("en_follows_busy", bram_EN, busy);
         if (busy) begin
            // A new read shows up as a fresh address; consecutive word indices always differ.
            if (!prev_busy || bram_A != prev_a) begin
               check("bram_addr", bram_A, AW'(((cmd_base + iss_cnt) % WL) * 4));
               iss_cnt++;
            end
            check("outstanding_over_fd", (iss_cnt - beat_cnt) > FD, 0);
         end else begin
            iss_cnt  = 0;
            beat_cnt = 0;
         end
         if (prev_stall) begin
            check("hold_valid", m_tvalid, 1);
            check("hold_data", m_tdata, prev_data);
            check("hold_last", m_tlast, prev_last);
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got data %0h expected no beat", m_tdata);
            end else begin
               check("beat_data", m_tdata, exp_q.pop_front());
               check("beat_last", m_tlast, exp_last_q.pop_front());
            end
            beat_cnt++;
            beats_seen++;
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
         prev_busy  = busy;
         prev_a     = bram_A;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int t0;
      int b;
      int l;
      int bs0;
      bit hit;
      for (int i = 0; i < WL; i++) mem[i] = DW'(i) * {16{8'h01}};

      repeat (3) @(negedge CLK);
      check_reset("reset");
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      // Basic read, then a wrap-around command started in the done cycle.
      ready_pct = 100;
      start_cmd(5, 4, 1'b0, t0);
      wait_done(t0, 4, 1'b1);
      start_cmd(62, 4, 1'b1, t0);
      wait_done(t0, 4, 1'b1);

      // Zero-length command.
      start_cmd(17, 0, 1'b0, t0);
      wait_done(t0, 0, 1'b1);

      // Heavy backpressure with a start pulse that must be ignored while busy.
      ready_pct = 30;
      start_cmd($urandom_range(0, 63), 16, 1'b0, t0);
      start = 1'b1;
      base  = IW'(3);
      len   = LW'(7);
      @(negedge CLK);
      start = 1'b0;
      wait_done(t0, 16, 1'b0);

      // Full-depth read.
      ready_pct = 70;
      start_cmd($urandom_range(0, 63), 64, 1'b0, t0);
      wait_done(t0, 64, 1'b0);

      // Random commands.
      for (int r = 0; r < 6; r++) begin
         b         = $urandom_range(0, 63);
         l         = $urandom_range(1, 64);
         ready_pct = (r % 2 == 0) ? 100 : $urandom_range(20, 90);
         start_cmd(b, l, 1'b0, t0);
         wait_done(t0, l, ready_pct == 100);
      end

      // Asynchronous reset after the third beat of a ten-beat command.
      ready_pct = 100;
      bs0 = beats_seen;
      start_cmd(20, 10, 1'b0, t0);
      hit = 1'b0;
      for (int n = 0; n < 200 && !hit; n++) begin
         @(posedge CLK);
         hit = (beats_seen - bs0 >= 3);
      end
      if (!hit) begin
         checks++;
         failures++;
         $display("FAIL reset_wait_beats: got %0d beats expected 3", beats_seen - bs0);
      end
      #2;
      RST_N = 1'b0;
      #1;
      check_reset("mid_reset");
      exp_q.delete();
      exp_last_q.delete();
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      start_cmd(0, 2, 1'b0, t0);
      wait_done(t0, 2, 1'b1);

      repeat (3) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
